// File: rtl/ir_receiver_sm.sv
// rtl/ir_receiver_sm.sv - IR car-control packet decoder: burst pulse counting, gap timing, command recovery.
module ir_receiver_sm #(
    parameter int CARRIER_PERIOD = 2667,
    parameter int SILENCE_END    = 2 * CARRIER_PERIOD,
    parameter int GAP_MAX        = 60 * CARRIER_PERIOD,
    parameter int START_MIN      = 70,
    parameter int START_MAX      = 106,
    parameter int SEL_MIN        = 15,
    parameter int SEL_MAX        = 32,
    parameter int ASSERT_MIN     = 33,
    parameter int ASSERT_MAX     = 60
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       IR_IN,
    output logic [3:0] COMMAND_OUT,
    output logic       PACKET_VALID,
    output logic       PACKET_ERROR,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        WAIT_START,
        WAIT_SEL,
        WAIT_BIT
    } state_t;

    localparam logic [17:0] SIL_END   = 18'(SILENCE_END);
    localparam logic [17:0] GAP_LIMIT = 18'(GAP_MAX);
    localparam logic [17:0] SIL_SAT   = 18'h3FFFF;

    state_t      state;
    logic        sync1, sync2, sync3;
    logic        ir_edge;
    logic [7:0]  pulse_cnt;
    logic [17:0] silence_cnt;
    logic        burst_active;
    logic [1:0]  bit_idx;
    logic [3:0]  shadow;

    logic rise;
    logic burst_end;
    logic watchdog;
    logic is_start, is_sel, is_assert;

    // Saturated count (255) never lands in a window, even if a window is widened.
    function automatic logic in_window(input logic [7:0] cnt, input int lo, input int hi);
        return (cnt != 8'hFF) && (int'(cnt) >= lo) && (int'(cnt) <= hi);
    endfunction

    // Silence is cleared from the same pre-edge term as ir_edge, so it reads 0 in the edge cycle.
    assign rise      = sync2 & ~sync3;
    assign burst_end = burst_active && (silence_cnt == SIL_END);
    assign watchdog  = (state != WAIT_START) && (silence_cnt == GAP_LIMIT);
    assign is_start  = in_window(pulse_cnt, START_MIN, START_MAX);
    assign is_sel    = in_window(pulse_cnt, SEL_MIN, SEL_MAX);
    assign is_assert = in_window(pulse_cnt, ASSERT_MIN, ASSERT_MAX);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= WAIT_START;
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            sync3        <= 1'b0;
            ir_edge      <= 1'b0;
            pulse_cnt    <= 8'd0;
            silence_cnt  <= 18'd0;
            burst_active <= 1'b0;
            bit_idx      <= 2'd0;
            shadow       <= 4'd0;
            COMMAND_OUT  <= 4'd0;
            PACKET_VALID <= 1'b0;
            PACKET_ERROR <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            sync1   <= IR_IN;
            sync2   <= sync1;
            sync3   <= sync2;
            ir_edge <= rise;

            if (rise)
                silence_cnt <= 18'd0;
            else if (silence_cnt != SIL_SAT)
                silence_cnt <= silence_cnt + 18'd1;

            if (burst_end)
                pulse_cnt <= 8'd0;
            else if (ir_edge && pulse_cnt != 8'hFF)
                pulse_cnt <= pulse_cnt + 8'd1;

            if (ir_edge)
                burst_active <= 1'b1;
            else if (burst_end)
                burst_active <= 1'b0;

            PACKET_VALID <= 1'b0;
            PACKET_ERROR <= 1'b0;

            case (state)
                WAIT_START: begin
                    if (burst_end && is_start) begin
                        state <= WAIT_SEL;
                        BUSY  <= 1'b1;
                    end
                end
                WAIT_SEL: begin
                    if (watchdog || (burst_end && !is_sel)) begin
                        PACKET_ERROR <= 1'b1;
                        state        <= WAIT_START;
                        BUSY         <= 1'b0;
                    end else if (burst_end) begin
                        bit_idx <= 2'd0;
                        state   <= WAIT_BIT;
                    end
                end
                WAIT_BIT: begin
                    if (watchdog || (burst_end && !is_sel && !is_assert)) begin
                        PACKET_ERROR <= 1'b1;
                        state        <= WAIT_START;
                        BUSY         <= 1'b0;
                    end else if (burst_end) begin
                        shadow[bit_idx] <= is_assert;
                        if (bit_idx == 2'd3) begin
                            COMMAND_OUT  <= {is_assert, shadow[2:0]};
                            PACKET_VALID <= 1'b1;
                            state        <= WAIT_START;
                            BUSY         <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 2'd1;
                        end
                    end
                end
                default: begin
                    state <= WAIT_START;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
